// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU host slice.
//   alu_op_e          - ALU opcode encoding (0..8; 9..15 are illegal)
//   ENC_KEY_DEFAULT   - default encryption key used by the ALU for OP_ENC
//   state_e           - alu_host sequencer states
//   op_is_legal()     - true for opcodes the ALU implements
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_NOT = 4'd7,
    OP_ENC = 4'd8
  } alu_op_e;

  localparam logic [7:0] ENC_KEY_DEFAULT = 8'hAB;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= OP_ENC;
  endfunction

endpackage

// File: rtl/alu_dec.sv
// alu_dec: undoes the ALU's ENC transform and checks it round-trips.
//   alu_result_i - raw ALU output for an ENC command
//   operands_i   - the {a,b} that were issued
//   plain_o      - alu_result_i XOR ENC_KEY
//   mismatch_o   - plain_o differs from operands_i
module alu_dec
  import alu_pkg::*;
#(
  parameter logic [7:0] ENC_KEY = ENC_KEY_DEFAULT
) (
  input  logic [7:0] alu_result_i,
  input  logic [7:0] operands_i,
  output logic [7:0] plain_o,
  output logic       mismatch_o
);

  always_comb begin
    plain_o    = alu_result_i ^ ENC_KEY;
    mismatch_o = (plain_o != operands_i);
  end

endmodule

// File: rtl/alu_host.sv
// alu_host: sequences one command at a time to a registered external ALU.
// Build option: define ALU_HOST_DECRYPT_EN to decrypt and verify ENC results.
// Ports:
//   clk, rst_n                       - clock, async active-low reset
//   cmd_valid/cmd_ready              - command handshake (ready only in IDLE)
//   cmd_op, cmd_a, cmd_b             - opcode and 4-bit operands
//   alu_operands, alu_opcode         - registered operand/opcode bus to ALU
//   alu_result, alu_flags            - ALU result and {overflow,carry}
//   rsp_valid/rsp_ready              - response handshake
//   rsp_data, rsp_flags, rsp_err     - response payload, held while stalled
module alu_host
  import alu_pkg::*;
#(
  parameter logic [7:0] ENC_KEY = ENC_KEY_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic [7:0] alu_operands,
  output logic [3:0] alu_opcode,
  input  logic [7:0] alu_result,
  input  logic [1:0] alu_flags,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_flags,
  output logic       rsp_err
);

  state_e     state_q, state_d;
  logic [7:0] operands_q, operands_d;
  logic [3:0] opcode_q, opcode_d;
  logic [7:0] data_q, data_d;
  logic [1:0] flags_q, flags_d;
  logic       err_q, err_d;

  logic [7:0] cap_data;
  logic       cap_err;

`ifdef ALU_HOST_DECRYPT_EN
  logic [7:0] dec_plain;
  logic       dec_mismatch;

  alu_dec #(
    .ENC_KEY(ENC_KEY)
  ) u_dec (
    .alu_result_i(alu_result),
    .operands_i  (operands_q),
    .plain_o     (dec_plain),
    .mismatch_o  (dec_mismatch)
  );
`else
  logic unused_key;
  assign unused_key = ^ENC_KEY;
`endif

  // Result qualification, evaluated against the issued operands/opcode.
  always_comb begin
    cap_data = alu_result;
    cap_err  = 1'b0;
    if (!op_is_legal(opcode_q)) begin
      cap_data = '0;
      cap_err  = 1'b1;
    end else if (opcode_q == OP_DIV && operands_q[3:0] == 4'd0) begin
      cap_err = 1'b1;
    end
`ifdef ALU_HOST_DECRYPT_EN
    else if (opcode_q == OP_ENC) begin
      cap_data = dec_plain;
      cap_err  = dec_mismatch;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    operands_d = operands_q;
    opcode_d   = opcode_q;
    data_d     = data_q;
    flags_d    = flags_q;
    err_d      = err_q;
    cmd_ready  = (state_q == ST_IDLE);
    rsp_valid  = (state_q == ST_RESP);
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          operands_d = {cmd_a, cmd_b};
          opcode_d   = cmd_op;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        data_d  = cap_data;
        flags_d = alu_flags;
        err_d   = cap_err;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      operands_q <= '0;
      opcode_q   <= '0;
      data_q     <= '0;
      flags_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      operands_q <= operands_d;
      opcode_q   <= opcode_d;
      data_q     <= data_d;
      flags_q    <= flags_d;
      err_q      <= err_d;
    end
  end

  assign alu_operands = operands_q;
  assign alu_opcode   = opcode_q;
  assign rsp_data     = data_q;
  assign rsp_flags    = flags_q;
  assign rsp_err      = err_q;

endmodule

// File: tb/tb_alu_host.sv
module tb_alu_host;

  localparam logic [7:0] KEY = 8'hAB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op, cmd_a, cmd_b;
  logic [7:0] alu_operands;
  logic [3:0] alu_opcode;
  logic [7:0] alu_result = 8'h00;
  logic [1:0] alu_flags  = 2'b00;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_flags;
  logic       rsp_err;
  logic       corrupt = 1'b0;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  always #5 clk = ~clk;

  alu_host #(.ENC_KEY(KEY)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .alu_operands(alu_operands),
    .alu_opcode  (alu_opcode),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_flags   (rsp_flags),
    .rsp_err     (rsp_err)
  );

  // ALU behaviour with plain arithmetic: returns {flags, result}.
  function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int s;
    logic [7:0] r;
    logic [1:0] f;
    r = 8'hEE;
    f = 2'b10;
    case (op)
      4'd0: begin
        s = int'(a) + int'(b);
        r = 8'(s % 16);
        f = {(a[3] == b[3]) && (r[3] != a[3]), s > 15};
      end
      4'd1: begin
        s = int'(a) - int'(b);
        r = 8'((s + 16) % 16);
        f = {(a[3] != b[3]) && (r[3] != a[3]), a < b};
      end
      4'd2: begin r = 8'(int'(a) * int'(b)); f = 2'b00; end
      4'd3: begin
        f = 2'b00;
        if (b == 4'd0) r = 8'h00;
        else r = {4'(a / b), 4'(a % b)};
      end
      4'd4: begin r = {4'h0, a & b}; f = 2'b00; end
      4'd5: begin r = {4'h0, a | b}; f = 2'b00; end
      4'd6: begin r = {4'h0, a ^ b}; f = 2'b00; end
      4'd7: begin r = {4'h0, ~a};    f = 2'b00; end
      4'd8: begin r = {a, b} ^ KEY;  f = 2'b00; end
      default: ;
    endcase
    return {f, r};
  endfunction

  // External ALU: registered, one-cycle latency, optional result corruption.
  always @(posedge clk) begin
    logic [9:0] v;
    v = alu_fn(alu_opcode, alu_operands[7:4], alu_operands[3:0]);
    alu_result <= v[7:0] ^ {7'b0, corrupt};
    alu_flags  <= v[9:8];
  end

  // Expected response: {err, flags, data}.
  function automatic logic [10:0] host_ref(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic bad);
    logic [9:0] v;
    logic [7:0] d;
    logic e;
    v = alu_fn(op, a, b);
    d = v[7:0] ^ {7'b0, bad};
    e = 1'b0;
    if (op > 4'd8) begin d = 8'h00; e = 1'b1; end
    else if (op == 4'd3 && b == 4'd0) e = 1'b1;
`ifdef ALU_HOST_DECRYPT_EN
    else if (op == 4'd8) begin d = d ^ KEY; e = (d != {a, b}); end
`endif
    return {e, v[9:8], d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge back in IDLE.
  // With qn set, a further command is presented during the stall and left pending.
  task automatic do_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input int unsigned stall, input logic [7:0] ed, input logic [1:0] ef,
                        input logic ee, input logic qn, input logic [3:0] nop,
                        input logic [3:0] na, input logic [3:0] nb);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1; rsp_ready = 1'b0;
    chk("ready_idle", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("operands", alu_operands, {a, b});
    chk("opcode", alu_opcode, op);
    chk("valid_c1", rsp_valid, 0);
    chk("ready_busy", cmd_ready, 0);
    @(negedge clk);
    chk("valid_c2", rsp_valid, 0);
    @(negedge clk);
    chk("valid_c3", rsp_valid, 1);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_flags", rsp_flags, ef);
    chk("rsp_err", rsp_err, ee);
    for (int i = 0; i < int'(stall); i++) begin
      if (qn) begin cmd_op = nop; cmd_a = na; cmd_b = nb; cmd_valid = 1'b1; end
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, ed);
      chk("hold_flags", rsp_flags, ef);
      chk("hold_err", rsp_err, ee);
      chk("hold_ready", cmd_ready, 0);
      chk("hold_operands", alu_operands, {a, b});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("valid_done", rsp_valid, 0);
    chk("ready_done", cmd_ready, 1);
    if (qn) chk("pending_not_taken", alu_operands, {a, b});
  endtask

  initial begin
    logic [10:0] r;
    logic [3:0] op, a, b;
    logic bad;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_operands", alu_operands, 0);
    chk("rst_opcode", alu_opcode, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_cmd(4'd0, 4'd9, 4'd8, 0, 8'h01, 2'b11, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    do_cmd(4'd3, 4'd13, 4'd4, 1, 8'h31, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    do_cmd(4'd3, 4'd13, 4'd0, 0, 8'h00, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
`ifdef ALU_HOST_DECRYPT_EN
    do_cmd(4'd8, 4'd3, 4'd5, 0, 8'h35, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    corrupt = 1'b1;
    do_cmd(4'd8, 4'd3, 4'd5, 0, 8'h34, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
`else
    do_cmd(4'd8, 4'd3, 4'd5, 0, 8'h9E, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    corrupt = 1'b1;
    do_cmd(4'd8, 4'd3, 4'd5, 0, 8'h9F, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
`endif
    corrupt = 1'b0;
    do_cmd(4'd9, 4'd6, 4'd2, 0, 8'h00, 2'b10, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);

    // Stalled response with a second command waiting behind it.
    do_cmd(4'd0, 4'd9, 4'd8, 5, 8'h01, 2'b11, 1'b0, 1'b1, 4'd1, 4'd5, 4'd7);
    do_cmd(4'd1, 4'd5, 4'd7, 0, 8'h0E, 2'b01, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);

    // Reset asserted while the command sits in CAPTURE.
    cmd_op = 4'd2; cmd_a = 4'd7; cmd_b = 4'd6; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_data", rsp_data, 0);
    chk("mid_rst_flags", rsp_flags, 0);
    chk("mid_rst_err", rsp_err, 0);
    chk("mid_rst_operands", alu_operands, 0);
    chk("mid_rst_opcode", alu_opcode, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_valid", rsp_valid, 0);
      chk("post_rst_ready", cmd_ready, 1);
    end

    for (int n = 0; n < 30; n++) begin
      op  = 4'($urandom_range(0, 15));
      a   = 4'($urandom_range(0, 15));
      b   = 4'($urandom_range(0, 15));
      bad = ($urandom_range(0, 3) == 0);
      corrupt = bad;
      r = host_ref(op, a, b, bad);
      do_cmd(op, a, b, $urandom_range(0, 2), r[7:0], r[9:8], r[10], 1'b0, 4'd0, 4'd0, 4'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
